inst_sram_responder: RTL
========================

Name: inst_sram_responder

Overview:
- Instruction-memory responder for the fetch stage's inst_sram request interface; the memory end of the fetch protocol.
- Holds a word-indexed instruction array. Each fetch address is a word index: sequential PC advances by 1.
- After reset, clears the array to NOP. Accepts program-load writes from a loader port.
- Returns read data with one-cycle latency and holds it stable while the fetch stage is stalled.

Parameters:
- DEPTH_LOG2, 10, log2 of array depth in 32-bit words (DEPTH = 1024).
- NOP_INST, 32'h00000013, word returned for cleared, out-of-range or reset data (RISC-V addi x0,x0,0).
- INIT_CLEAR, 1, when 1 the array is cleared to NOP_INST after reset; when 0 the block goes directly to SERVE.

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- inst_sram_en  input  1  fetch request, qualified this cycle.
- inst_sram_addr  input  64  word index to read.
- inst_sram_rdata  output  32  read data, registered.
- inst_sram_en_toif  output  1  fetch grant; combinational; fetch stage gates inst_sram_en with it.
- load_valid  input  1  loader write request.
- load_addr  input  64  loader word index.
- load_data  input  32  loader write data.
- load_ready  output  1  write accepted this cycle when load_valid && load_ready.
- init_done  output  1  high once the clear sweep has finished.
- addr_err  output  1  sticky flag; set by any out-of-range fetch or load.
- fetch_count  output  32  accepted fetches; saturates at 32'hFFFFFFFF.

Behaviour:
- Reset (async, resetn low) values:
  - state = INIT, or SERVE if INIT_CLEAR = 0.
  - clr_ptr = 0.
  - inst_sram_rdata = NOP_INST.
  - addr_err = 0, fetch_count = 0.
  - init_done = 0, or 1 if INIT_CLEAR = 0.
- The array itself is not reset.
- FSM, 2 states:
  - INIT: writes NOP_INST to array[clr_ptr] each cycle and increments clr_ptr. When clr_ptr == DEPTH-1, that write completes and the next state is SERVE with init_done = 1. INIT lasts exactly DEPTH cycles.
  - SERVE: terminal until reset.
- In INIT: inst_sram_en_toif = 0, load_ready = 0. Any inst_sram_en is ignored and rdata holds.
- Grants in SERVE:
  - load_ready = 1.
  - inst_sram_en_toif = !load_valid. A pending load blocks fetch for that cycle; load has priority.
- Fetch accept = inst_sram_en && inst_sram_en_toif.
  - On the accepting edge: rdata <= array[addr[DEPTH_LOG2-1:0]], visible the cycle after accept (latency 1).
  - If addr[63:DEPTH_LOG2] != 0: rdata <= NOP_INST and addr_err <= 1.
- No accept: rdata holds its last value. This covers a stalled fetch stage, a blocked grant, and INIT.
- Load write (load_valid && load_ready):
  - array[load_addr[DEPTH_LOG2-1:0]] <= load_data.
  - If the upper address bits are nonzero, the write is dropped and addr_err <= 1.
- Fetch and load never access the array in the same cycle, because the grant rule excludes it. A fetch of the address just loaded, issued in the next cycle, returns the new data (write-before-read across cycles).
- fetch_count increments by 1 per accepted fetch and holds at all-ones.
- addr_err clears only on reset.
- Reset asserted mid-INIT or mid-SERVE: immediate return to the reset values above; the clear sweep restarts at 0.
- inst_sram_en_toif and load_ready are combinational from state and load_valid only. There is no path from inst_sram_en or inst_sram_addr to them, so there is no loop with the fetch stage.

Decomposition:
- Shared package mycpu.h defines:
  - INST_NOP = 32'h00000013.
  - IRAM_DEPTH_LOG2 default.
  - State encodings IRAM_INIT = 1'b0, IRAM_SERVE = 1'b1.
- One sub-module: iram_array. Single-port synchronous RAM: we, waddr/raddr share one address input, registered read output. Read enable gates the output register so it holds when disabled.
- FSM, grant logic, range check and counters live in inst_sram_responder.

Test Plan:
- Reset then idle, INIT_CLEAR = 1:
  - inst_sram_en_toif = 0 and init_done = 0 for 1024 cycles; init_done = 1 at cycle 1024.
  - A fetch of addr 5 returns 32'h00000013.
- Load then fetch:
  - Load addr 3 = 32'h00500093, load addr 4 = 32'h00100113.
  - Fetch addr 3, then fetch addr 4 back-to-back: rdata = 32'h00500093 one cycle after the first accept, 32'h00100113 one cycle after the second; fetch_count = 2.
- Stall hold:
  - Fetch addr 3, then hold inst_sram_en = 0 for 4 cycles: rdata stays 32'h00500093 for all 4 cycles; fetch_count unchanged.
- Collision:
  - load_valid = 1 and inst_sram_en = 1 in the same cycle: inst_sram_en_toif = 0, the load is written and rdata holds.
  - The next cycle, fetch of the loaded address returns the new data.
- Out of range:
  - Fetch addr 64'h400 (DEPTH 1024): rdata = 32'h00000013 and addr_err = 1, staying set after later valid fetches.
  - Load to 64'h1_0000_0000 is dropped, with addr_err = 1.
- Async reset at INIT cycle 500:
  - Outputs return to reset values immediately without a clock edge.
  - After release, INIT runs a full 1024 cycles before init_done = 1.

Source files
------------

// File: rtl/inst_sram_responder_pkg.sv
// rtl/inst_sram_responder_pkg.sv - shared constants and state encoding for the instruction SRAM responder
package inst_sram_responder_pkg;

    localparam logic [31:0] INST_NOP        = 32'h00000013;
    localparam int          IRAM_DEPTH_LOG2 = 10;

    typedef enum logic {
        IRAM_INIT  = 1'b0,
        IRAM_SERVE = 1'b1
    } iram_state_t;

endpackage

// File: rtl/inst_sram_responder_iram_array.sv
// rtl/inst_sram_responder_iram_array.sv - single-port synchronous instruction RAM with held read register
module iram_array #(
    parameter int          AW       = 10,
    parameter logic [31:0] NOP_DATA = 32'h00000013
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          we,
    input  logic          re,
    input  logic          rd_nop,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register only loads on an enabled read, so it holds through stalls.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata <= NOP_DATA;
        end else if (re) begin
            rdata <= rd_nop ? NOP_DATA : mem[addr];
        end
    end

endmodule

// File: rtl/inst_sram_responder.sv
// rtl/inst_sram_responder.sv - instruction memory responder for the fetch stage with loader port
module inst_sram_responder
    import inst_sram_responder_pkg::*;
#(
    parameter int          DEPTH_LOG2 = IRAM_DEPTH_LOG2,
    parameter logic [31:0] NOP_INST   = INST_NOP,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_en,
    input  logic [63:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_sram_en_toif,
    input  logic        load_valid,
    input  logic [63:0] load_addr,
    input  logic [31:0] load_data,
    output logic        load_ready,
    output logic        init_done,
    output logic        addr_err,
    output logic [31:0] fetch_count
);

    iram_state_t           state;
    logic [DEPTH_LOG2-1:0] clr_ptr;

    logic                  in_serve;
    logic                  fetch_acc;
    logic                  load_acc;
    logic                  fetch_oor;
    logic                  load_oor;

    logic                  ram_we;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [31:0]           ram_wdata;

    // Grants depend only on state and load_valid, keeping the fetch handshake loop-free.
    assign in_serve          = (state == IRAM_SERVE);
    assign load_ready        = in_serve;
    assign inst_sram_en_toif = in_serve && !load_valid;

    assign fetch_acc = inst_sram_en && inst_sram_en_toif;
    assign load_acc  = load_valid && load_ready;
    assign fetch_oor = |inst_sram_addr[63:DEPTH_LOG2];
    assign load_oor  = |load_addr[63:DEPTH_LOG2];

    // Single RAM port: the clear sweep owns it in INIT, a load owns it when valid, fetch otherwise.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = inst_sram_addr[DEPTH_LOG2-1:0];
        ram_wdata = load_data;
        if (!in_serve) begin
            ram_we    = 1'b1;
            ram_addr  = clr_ptr;
            ram_wdata = NOP_INST;
        end else if (load_acc) begin
            ram_we   = !load_oor;
            ram_addr = load_addr[DEPTH_LOG2-1:0];
        end
    end

    iram_array #(
        .AW       (DEPTH_LOG2),
        .NOP_DATA (NOP_INST)
    ) u_iram_array (
        .clk    (clk),
        .resetn (resetn),
        .we     (ram_we),
        .re     (fetch_acc),
        .rd_nop (fetch_oor),
        .addr   (ram_addr),
        .wdata  (ram_wdata),
        .rdata  (inst_sram_rdata)
    );

    // Clear sweep FSM: one NOP write per cycle, then serve until reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= INIT_CLEAR ? IRAM_INIT : IRAM_SERVE;
            clr_ptr   <= '0;
            init_done <= !INIT_CLEAR;
        end else begin
            case (state)
                IRAM_INIT: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (&clr_ptr) begin
                        state     <= IRAM_SERVE;
                        init_done <= 1'b1;
                    end
                end
                default: begin
                    state <= IRAM_SERVE;
                end
            endcase
        end
    end

    // Sticky range error and saturating count of accepted fetches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_err    <= 1'b0;
            fetch_count <= '0;
        end else begin
            if ((fetch_acc && fetch_oor) || (load_acc && load_oor)) begin
                addr_err <= 1'b1;
            end
            if (fetch_acc && (fetch_count != 32'hFFFFFFFF)) begin
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule
